ov_cfg_sequencer: RTL and testbench

// - Sequences the OV camera's SCCB register initialisation after reset.
// - Holds off for the power-up delay, then walks a register table of {addr,data} entries.
// - Issues one write per entry to the SCCB master over a req/ack handshake, retrying NACKed writes.
// - Reports busy/done/error. The capture path is qualified with cfg_done until the sensor is configured.
//

---
 rtl/ov_pkg.sv | 42 ++++
 rtl/ov_cfg_rom.sv | 31 +++
 rtl/ov_cfg_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_ov_cfg_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ov_pkg.sv
// ov_pkg: shared types and constants for the OV sensor configuration sequencer.
//   CFG_END / CFG_DLY : reserved register addresses used as table markers
//   cfg_entry_t       : one {addr,data} table entry
//   cfg_table_t       : packed ROM image, entry i at bits [16*i +: 16]
//   cfg_state_t       : sequencer FSM states
package ov_pkg;

    localparam logic [7:0] CFG_END = 8'hFE;  // end of table
    localparam logic [7:0] CFG_DLY = 8'hFF;  // wait <data> ms before the next entry

    // Largest table the 8-bit err_idx can describe.
    localparam int MAX_REGS = 256;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } cfg_entry_t;

    typedef logic [16*MAX_REGS-1:0] cfg_table_t;

    // Soft reset, 1 ms settle, clock prescaler, end marker; unused tail is all end markers.
    localparam cfg_table_t DEFAULT_TABLE = {
        {(MAX_REGS-4){16'hFE00}},
        16'hFE00,
        16'h1101,
        16'hFF01,
        16'h1280
    };

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_DELAY,
        ST_DONE,
        ST_FAIL
    } cfg_state_t;

endpackage

// File: rtl/ov_cfg_rom.sv
// ov_cfg_rom: register table with a synchronous one-cycle read.
//   clk      : clock
//   rd_idx   : entry index, sampled every posedge
//   rd_entry : {addr,data} of the entry addressed in the previous cycle
module ov_cfg_rom
    import ov_pkg::*;
#(
    parameter int         NUM_REGS  = 64,
    parameter int         IDX_W     = 6,
    parameter cfg_table_t ROM_TABLE = DEFAULT_TABLE
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output cfg_entry_t       rd_entry
);

    cfg_entry_t rom_mem [NUM_REGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_rom
            assign rom_mem[gi] = cfg_entry_t'(ROM_TABLE[16*gi +: 16]);
        end
    endgenerate

    // No reset on the read register so the table maps onto block RAM/ROM.
    always_ff @(posedge clk) begin
        rd_entry <= rom_mem[rd_idx];
    end

endmodule

// File: rtl/ov_cfg_sequencer.sv
// ov_cfg_sequencer: after reset waits PWRUP_MS, then walks the register table and
// writes each entry to the SCCB master, retrying NACKed writes up to MAX_RETRY attempts.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : re-run the table (only honoured in DONE/FAIL)
//   cfg_req/addr/data   : write request to the SCCB master
//   cfg_ack/cfg_nack    : one-cycle completion pulses from the master
//   cfg_busy/done/err   : status levels
//   err_idx             : index of the entry that ran out of retries
module ov_cfg_sequencer
    import ov_pkg::*;
#(
    parameter int         CLK_HZ    = 50_000_000,
    parameter int         PWRUP_MS  = 20,
    parameter int         NUM_REGS  = 64,
    parameter int         MAX_RETRY = 3,
    parameter cfg_table_t ROM_TABLE = DEFAULT_TABLE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       cfg_req,
    output logic [7:0] cfg_addr,
    output logic [7:0] cfg_data,
    input  logic       cfg_ack,
    input  logic       cfg_nack,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [7:0] err_idx
);

    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RETRY_W  = $clog2(MAX_RETRY + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_REGS - 1);
    localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [7:0]         PWRUP_LAST  = 8'(PWRUP_MS - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    cfg_state_t         state_reg,    state_next;
    logic [IDX_W-1:0]   idx_reg,      idx_next;
    logic [RETRY_W-1:0] retry_reg,    retry_next;
    logic [TICK_W-1:0]  tick_cnt_reg, tick_cnt_next;
    logic [7:0]         ms_cnt_reg,   ms_cnt_next;
    logic [7:0]         dly_ms_reg,   dly_ms_next;
    cfg_entry_t         entry_reg,    entry_next;
    logic [7:0]         err_idx_reg,  err_idx_next;

    cfg_entry_t         rom_entry;
    logic               tick;
    logic               at_last;
    logic [RETRY_W-1:0] retry_inc;

    ov_cfg_rom #(
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W),
        .ROM_TABLE (ROM_TABLE)
    ) u_rom (
        .clk      (clk),
        .rd_idx   (idx_reg),
        .rd_entry (rom_entry)
    );

    assign tick      = (tick_cnt_reg == TICK_LAST);
    assign at_last   = (idx_reg == LAST_IDX);
    assign retry_inc = retry_reg + RETRY_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_PWRUP;
            idx_reg      <= '0;
            retry_reg    <= '0;
            tick_cnt_reg <= '0;
            ms_cnt_reg   <= '0;
            dly_ms_reg   <= '0;
            entry_reg    <= '0;
            err_idx_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            retry_reg    <= retry_next;
            tick_cnt_reg <= tick_cnt_next;
            ms_cnt_reg   <= ms_cnt_next;
            dly_ms_reg   <= dly_ms_next;
            entry_reg    <= entry_next;
            err_idx_reg  <= err_idx_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        retry_next    = retry_reg;
        tick_cnt_next = tick ? '0 : tick_cnt_reg + TICK_W'(1);
        ms_cnt_next   = tick ? ms_cnt_reg + 8'd1 : ms_cnt_reg;
        dly_ms_next   = dly_ms_reg;
        entry_next    = entry_reg;
        err_idx_next  = err_idx_reg;

        case (state_reg)
            ST_PWRUP: begin
                if (tick && (ms_cnt_reg == PWRUP_LAST)) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                entry_next = rom_entry;
                if (rom_entry.addr == CFG_END) begin
                    state_next = ST_DONE;
                end else if (rom_entry.addr == CFG_DLY) begin
                    // Restart the ms timebase so the delay is a whole number of ms.
                    dly_ms_next   = rom_entry.data;
                    tick_cnt_next = '0;
                    ms_cnt_next   = '0;
                    state_next    = ST_DELAY;
                end else begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // nack wins when both arrive together.
                if (cfg_nack) begin
                    if (retry_inc < RETRY_LIMIT) begin
                        retry_next = retry_inc;
                        state_next = ST_GAP;
                    end else begin
                        err_idx_next = 8'(idx_reg);
                        state_next   = ST_FAIL;
                    end
                end else if (cfg_ack) begin
                    retry_next = '0;
                    if (at_last) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_GAP: begin
                state_next = ST_ISSUE;
            end
            ST_DELAY: begin
                if ((dly_ms_reg == 8'd0) || (tick && (ms_cnt_reg == dly_ms_reg - 8'd1))) begin
                    if (at_last) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_DONE, ST_FAIL: begin
                // A re-run skips the power-up wait: the sensor is already powered.
                if (start) begin
                    idx_next     = '0;
                    retry_next   = '0;
                    err_idx_next = '0;
                    state_next   = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_PWRUP;
            end
        endcase
    end

    // Request is decoded straight from state so an async reset drops it immediately.
    assign cfg_req  = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
    assign cfg_addr = cfg_req ? entry_reg.addr : 8'd0;
    assign cfg_data = cfg_req ? entry_reg.data : 8'd0;
    assign cfg_busy = (state_reg != ST_DONE) && (state_reg != ST_FAIL);
    assign cfg_done = (state_reg == ST_DONE);
    assign cfg_err  = (state_reg == ST_FAIL);
    assign err_idx  = err_idx_reg;

endmodule

// File: tb/tb_ov_cfg_sequencer.sv
// tb_ov_cfg_sequencer: directed bench for ov_cfg_sequencer.
// Main instance: 20 clk per ms, 3 ms power-up, default table {12,80},{FF,01},{11,01},{FE,..}.
// Second instance: 4-entry table with no end marker.
module tb_ov_cfg_sequencer;
    import ov_pkg::*;

    localparam int DIV       = 20;           // clk cycles per ms (CLK_HZ = 20_000)
    localparam int PW        = 3;            // power-up ms
    localparam int PWRUP_CYC = PW*DIV + 2;   // release -> PWRUP, FETCH, DECODE -> req
    localparam int DLY_GAP   = DIV + 4;      // ack -> FETCH, DECODE, 1 ms DELAY, FETCH, DECODE -> req

    localparam cfg_table_t TABLE4 = {
        {(MAX_REGS-4){16'h0000}},
        16'h0404, 16'h0303, 16'h0202, 16'h0101
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cfg_ack = 1'b0, cfg_nack = 1'b0;
    logic       cfg_req, cfg_busy, cfg_done, cfg_err;
    logic [7:0] cfg_addr, cfg_data, err_idx;

    logic       ack4 = 1'b0, nack4 = 1'b0;
    logic       req4, busy4, done4, err4;
    logic [7:0] addr4, data4, err_idx4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ov_cfg_sequencer #(
        .CLK_HZ(20_000), .PWRUP_MS(PW), .NUM_REGS(8), .MAX_RETRY(3)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ack(cfg_ack), .cfg_nack(cfg_nack),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .err_idx(err_idx)
    );

    ov_cfg_sequencer #(
        .CLK_HZ(20_000), .PWRUP_MS(PW), .NUM_REGS(4), .MAX_RETRY(3), .ROM_TABLE(TABLE4)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(1'b0),
        .cfg_req(req4), .cfg_addr(addr4), .cfg_data(data4),
        .cfg_ack(ack4), .cfg_nack(nack4),
        .cfg_busy(busy4), .cfg_done(done4), .cfg_err(err4), .err_idx(err_idx4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until the selected instance raises req; n = steps taken.
    task automatic wait_req(input bit sel, input int max, output int n);
        n = 0;
        while (!(sel ? req4 : cfg_req) && n < max) begin
            step();
            n++;
        end
        if (!(sel ? req4 : cfg_req)) chk("req_timeout", 32'(sel ? req4 : cfg_req), 32'd1);
    endtask

    // One write on the main instance: wait for req, hold 4 cycles, respond, check req drops.
    task automatic serve(input string tag, input logic [7:0] ea, input logic [7:0] ed,
                         input int exp_wait, input logic a, input logic n, input logic mid_start);
        int w;
        wait_req(1'b0, 300, w);
        chk({tag, "_wait"}, 32'(w), 32'(exp_wait));
        chk({tag, "_addr"}, 32'(cfg_addr), 32'(ea));
        chk({tag, "_data"}, 32'(cfg_data), 32'(ed));
        for (int k = 0; k < 4; k++) begin
            if (k == 1 && mid_start) start = 1'b1;
            step();
            start = 1'b0;
        end
        chk({tag, "_hold"}, 32'({cfg_req, cfg_addr, cfg_data}), 32'({1'b1, ea, ed}));
        cfg_ack = a;
        cfg_nack = n;
        step();
        cfg_ack = 1'b0;
        cfg_nack = 1'b0;
        chk({tag, "_drop"}, 32'(cfg_req), 32'd0);
        $display("write %s addr=%02h data=%02h ack=%0b nack=%0b wait=%0d", tag, ea, ed, a, n, w);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cnt;

        // Reset values
        step();
        step();
        chk("rst_req",  32'(cfg_req),  32'd0);
        chk("rst_addr", 32'(cfg_addr), 32'd0);
        chk("rst_data", 32'(cfg_data), 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd1);
        chk("rst_done", 32'(cfg_done), 32'd0);
        chk("rst_err",  32'(cfg_err),  32'd0);
        chk("rst_eidx", 32'(err_idx),  32'd0);
        rst_n = 1'b1;

        // Normal run: power-up delay, 1 ms delay entry, end marker
        serve("t1_e0", 8'h12, 8'h80, PWRUP_CYC, 1'b1, 1'b0, 1'b0);
        serve("t1_e2", 8'h11, 8'h01, DLY_GAP,   1'b1, 1'b0, 1'b0);
        chk("t1_busy_pre", 32'(cfg_busy), 32'd1);
        step();
        step();
        chk("t1_done", 32'(cfg_done), 32'd1);
        chk("t1_busy", 32'(cfg_busy), 32'd0);
        chk("t1_err",  32'(cfg_err),  32'd0);

        // Two NACKs then ACK on entry 2
        pulse_start();
        serve("t2_e0",  8'h12, 8'h80, 2,       1'b1, 1'b0, 1'b0);
        serve("t2_e2a", 8'h11, 8'h01, DLY_GAP, 1'b0, 1'b1, 1'b0);
        serve("t2_e2b", 8'h11, 8'h01, 1,       1'b0, 1'b1, 1'b0);
        serve("t2_e2c", 8'h11, 8'h01, 1,       1'b1, 1'b0, 1'b0);
        step();
        step();
        chk("t2_done", 32'(cfg_done), 32'd1);
        chk("t2_err",  32'(cfg_err),  32'd0);

        // Three NACKs on entry 2 -> FAIL
        pulse_start();
        serve("t3_e0",  8'h12, 8'h80, 2,       1'b1, 1'b0, 1'b0);
        serve("t3_e2a", 8'h11, 8'h01, DLY_GAP, 1'b0, 1'b1, 1'b0);
        serve("t3_e2b", 8'h11, 8'h01, 1,       1'b0, 1'b1, 1'b0);
        serve("t3_e2c", 8'h11, 8'h01, 1,       1'b0, 1'b1, 1'b0);
        chk("t3_err",  32'(cfg_err),  32'd1);
        chk("t3_eidx", 32'(err_idx),  32'd2);
        chk("t3_busy", 32'(cfg_busy), 32'd0);
        chk("t3_done", 32'(cfg_done), 32'd0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (cfg_req) cnt++;
        end
        chk("t3_no_req", 32'(cnt), 32'd0);

        // Restart from FAIL without power-up; simultaneous ack+nack counts as a nack
        pulse_start();
        chk("t4_err_clr",  32'(cfg_err),  32'd0);
        chk("t4_eidx_clr", 32'(err_idx),  32'd0);
        chk("t4_busy",     32'(cfg_busy), 32'd1);
        serve("t4_e0a", 8'h12, 8'h80, 2, 1'b1, 1'b1, 1'b0);
        serve("t4_e0b", 8'h12, 8'h80, 1, 1'b1, 1'b0, 1'b0);
        // Stray ack while req is low
        for (int k = 0; k < 5; k++) step();
        cfg_ack = 1'b1;
        step();
        cfg_ack = 1'b0;
        chk("t4_stray_req",  32'(cfg_req),  32'd0);
        chk("t4_stray_busy", 32'(cfg_busy), 32'd1);
        serve("t4_e2a", 8'h11, 8'h01, DLY_GAP - 6, 1'b0, 1'b1, 1'b0);
        serve("t4_e2b", 8'h11, 8'h01, 1,           1'b0, 1'b1, 1'b0);
        serve("t4_e2c", 8'h11, 8'h01, 1,           1'b1, 1'b0, 1'b0);
        step();
        step();
        chk("t4_done", 32'(cfg_done), 32'd1);
        chk("t4_err",  32'(cfg_err),  32'd0);

        // start while busy is ignored
        pulse_start();
        serve("t5_e0", 8'h12, 8'h80, 2,       1'b1, 1'b0, 1'b1);
        serve("t5_e2", 8'h11, 8'h01, DLY_GAP, 1'b1, 1'b0, 1'b0);
        step();
        step();
        chk("t5_done", 32'(cfg_done), 32'd1);

        // Reset asserted during WAIT
        pulse_start();
        serve("t6_e0", 8'h12, 8'h80, 2, 1'b1, 1'b0, 1'b0);
        wait_req(1'b0, 300, w);
        chk("t6_wait", 32'(w), 32'(DLY_GAP));
        step();
        chk("t6_req_in_wait", 32'(cfg_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_req_async", 32'(cfg_req),  32'd0);
        chk("t6_busy_rst",  32'(cfg_busy), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        serve("t6_r0", 8'h12, 8'h80, PWRUP_CYC, 1'b1, 1'b0, 1'b0);
        serve("t6_r2", 8'h11, 8'h01, DLY_GAP,   1'b1, 1'b0, 1'b0);
        step();
        step();
        chk("t6_done", 32'(cfg_done), 32'd1);

        // Table without end marker: exactly NUM_REGS writes, then done
        for (int i = 0; i < 4; i++) begin
            wait_req(1'b1, 300, w);
            chk("t7_addr", 32'(addr4), 32'(i + 1));
            chk("t7_data", 32'(data4), 32'(i + 1));
            step();
            step();
            ack4 = 1'b1;
            step();
            ack4 = 1'b0;
            chk("t7_done_step", 32'(done4), 32'(i == 3));
            $display("write t7_e%0d addr=%02h data=%02h ack=1 nack=0 wait=%0d", i, i + 1, i + 1, w);
        end
        chk("t7_busy", 32'(busy4), 32'd0);
        chk("t7_err",  32'(err4),  32'd0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (req4) cnt++;
        end
        chk("t7_no_more_req", 32'(cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
